// File: rtl/gpu_cmd_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gpu_cmd_queue
// Purpose  : DEPTH-entry command FIFO feeding a GPU through a four-state
//            issue FSM (IDLE, SETUP, STROBE, WAIT) with one-cycle strobes.
// Revision : 1.0  initial release
// ============================================================================
module gpu_cmd_queue #(
    parameter int FB_WIDTH  = 400,
    parameter int FB_HEIGHT = 240,
    parameter int DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_op,
    input  logic [31:0]                   cmd_address,
    input  logic [15:0]                   cmd_address_x,
    input  logic [15:0]                   cmd_address_y,
    input  logic [15:0]                   cmd_image_width,
    input  logic [$clog2(FB_WIDTH)+1:0]   cmd_width,
    input  logic [$clog2(FB_HEIGHT)+1:0]  cmd_height,
    input  logic [$clog2(FB_WIDTH)+1:0]   cmd_x,
    input  logic [$clog2(FB_HEIGHT)+1:0]  cmd_y,
    input  logic [15:0]                   cmd_clear_color,
    output logic [31:0]                   ctrl_address,
    output logic [15:0]                   ctrl_address_x,
    output logic [15:0]                   ctrl_address_y,
    output logic [15:0]                   ctrl_image_width,
    output logic [$clog2(FB_WIDTH)+1:0]   ctrl_width,
    output logic [$clog2(FB_HEIGHT)+1:0]  ctrl_height,
    output logic [$clog2(FB_WIDTH)+1:0]   ctrl_x,
    output logic [$clog2(FB_HEIGHT)+1:0]  ctrl_y,
    output logic [15:0]                   ctrl_clear_color,
    output logic                          ctrl_draw,
    output logic                          ctrl_clear,
    input  logic                          gpu_busy,
    output logic [$clog2(DEPTH):0]        queue_count,
    output logic                          overflow,
    input  logic                          overflow_clear,
    output logic [15:0]                   issued_count,
    output logic                          idle
);

    localparam int XW = $clog2(FB_WIDTH) + 2;
    localparam int YW = $clog2(FB_HEIGHT) + 2;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 1 + 32 + 16 * 3 + 2 * XW + 2 * YW + 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [EW-1:0] r_head;
    state_t        r_state;
    logic          r_draw;
    logic          r_clear;
    logic          r_overflow;
    logic [15:0]   r_issued;

    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_head_op;
    logic [EW-1:0] w_push_word;

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_push      = cmd_valid && !w_full;
    assign w_pop       = (r_state == S_WAIT) && !gpu_busy;
    assign w_push_word = {cmd_op, cmd_address, cmd_address_x, cmd_address_y,
                          cmd_image_width, cmd_width, cmd_height, cmd_x, cmd_y,
                          cmd_clear_color};

    // The head copy is taken when issue starts, so fields stay put through WAIT.
    assign {w_head_op, ctrl_address, ctrl_address_x, ctrl_address_y,
            ctrl_image_width, ctrl_width, ctrl_height, ctrl_x, ctrl_y,
            ctrl_clear_color} = r_head;

    assign cmd_ready    = !w_full;
    assign queue_count  = r_count;
    assign overflow     = r_overflow;
    assign issued_count = r_issued;
    assign ctrl_draw    = r_draw;
    assign ctrl_clear   = r_clear;
    assign idle         = (r_count == '0) && (r_state == S_IDLE) && !gpu_busy;

    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_mem[r_wr_ptr] <= w_push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_head     <= '0;
            r_state    <= S_IDLE;
            r_draw     <= 1'b0;
            r_clear    <= 1'b0;
            r_overflow <= 1'b0;
            r_issued   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            // A new overflow wins over a same-cycle clear request.
            if (cmd_valid && w_full) begin
                r_overflow <= 1'b1;
            end else if (overflow_clear) begin
                r_overflow <= 1'b0;
            end

            r_draw  <= 1'b0;
            r_clear <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if ((r_count != '0) && !gpu_busy) begin
                        r_head  <= r_mem[r_rd_ptr];
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_draw  <= !w_head_op;
                    r_clear <= w_head_op;
                    r_state <= S_STROBE;
                end
                S_STROBE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!gpu_busy) begin
                        r_issued <= r_issued + 16'd1;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gpu_cmd_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gpu_cmd_queue
// Purpose  : Directed and randomized checks of gpu_cmd_queue against a
//            queue-based reference model with a simple GPU busy responder.
// Revision : 1.0  initial release
// ============================================================================
module tb_gpu_cmd_queue;

    localparam int DEPTH = 4;
    localparam int XW    = 11;
    localparam int YW    = 10;
    localparam int CW    = 3;

    typedef struct packed {
        logic          op;
        logic [31:0]   addr;
        logic [15:0]   ax;
        logic [15:0]   ay;
        logic [15:0]   iw;
        logic [XW-1:0] w;
        logic [YW-1:0] h;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [15:0]   color;
    } cmd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    cmd_t          cur;
    logic [31:0]   ctrl_address;
    logic [15:0]   ctrl_address_x, ctrl_address_y, ctrl_image_width, ctrl_clear_color;
    logic [XW-1:0] ctrl_width, ctrl_x;
    logic [YW-1:0] ctrl_height, ctrl_y;
    logic          ctrl_draw, ctrl_clear, gpu_busy;
    logic [CW-1:0] queue_count;
    logic          overflow, overflow_clear, idle;
    logic [15:0]   issued_count;

    gpu_cmd_queue #(.FB_WIDTH(400), .FB_HEIGHT(240), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cur.op), .cmd_address(cur.addr), .cmd_address_x(cur.ax),
        .cmd_address_y(cur.ay), .cmd_image_width(cur.iw), .cmd_width(cur.w),
        .cmd_height(cur.h), .cmd_x(cur.x), .cmd_y(cur.y),
        .cmd_clear_color(cur.color),
        .ctrl_address(ctrl_address), .ctrl_address_x(ctrl_address_x),
        .ctrl_address_y(ctrl_address_y), .ctrl_image_width(ctrl_image_width),
        .ctrl_width(ctrl_width), .ctrl_height(ctrl_height), .ctrl_x(ctrl_x),
        .ctrl_y(ctrl_y), .ctrl_clear_color(ctrl_clear_color),
        .ctrl_draw(ctrl_draw), .ctrl_clear(ctrl_clear), .gpu_busy(gpu_busy),
        .queue_count(queue_count), .overflow(overflow),
        .overflow_clear(overflow_clear), .issued_count(issued_count), .idle(idle)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: pending commands plus the command currently in service,
    // whose age counts cycles since service began (0 setup, 1 strobe, 2+ wait).
    cmd_t        mq[$];
    cmd_t        m_ctrl;
    bit          m_active;
    int          m_age;
    bit          m_ovf;
    logic [15:0] m_issued;

    cmd_t obs_q[$];
    int   obs_cyc[$];
    int   busy_cnt;
    int   busy_len;
    bit   force_busy;

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.op    = 1'($urandom_range(0, 1));
        c.addr  = $urandom;
        c.ax    = 16'($urandom);
        c.ay    = 16'($urandom);
        c.iw    = 16'($urandom);
        c.w     = XW'($urandom);
        c.h     = YW'($urandom);
        c.x     = XW'($urandom);
        c.y     = YW'($urandom);
        c.color = 16'($urandom);
        return c;
    endfunction

    function automatic cmd_t dut_fields();
        cmd_t c;
        c.op    = 1'b0;
        c.addr  = ctrl_address;
        c.ax    = ctrl_address_x;
        c.ay    = ctrl_address_y;
        c.iw    = ctrl_image_width;
        c.w     = ctrl_width;
        c.h     = ctrl_height;
        c.x     = ctrl_x;
        c.y     = ctrl_y;
        c.color = ctrl_clear_color;
        return c;
    endfunction

    task automatic model_edge();
        int sz;
        bit do_pop, do_start, do_push;
        sz = mq.size();
        if (!reset) begin
            mq.delete();
            m_active = 0; m_age = 0; m_ovf = 0; m_issued = '0; m_ctrl = '0;
        end else begin
            do_pop   = m_active && (m_age >= 2) && !gpu_busy;
            do_start = !m_active && (sz > 0) && !gpu_busy;
            do_push  = cmd_valid && (sz < DEPTH);
            if (cmd_valid && sz == DEPTH) m_ovf = 1;
            else if (overflow_clear)      m_ovf = 0;
            if (do_pop) begin
                void'(mq.pop_front());
                m_issued = m_issued + 16'd1;
                m_active = 0;
            end else if (m_active) begin
                m_age++;
            end
            if (do_start) begin
                m_ctrl = mq[0]; m_active = 1; m_age = 0;
            end
            if (do_push) mq.push_back(cur);
        end
    endtask

    task automatic step();
        cmd_t c;
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        if (busy_cnt > 0) busy_cnt--;
        if (ctrl_draw || ctrl_clear) begin
            c = dut_fields();
            c.op = ctrl_clear;
            obs_q.push_back(c);
            obs_cyc.push_back(cyc);
            busy_cnt = busy_len;
        end
        gpu_busy = force_busy || (busy_cnt > 0);
    endtask

    task automatic push(input cmd_t c);
        cur = c; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(); step();
        n_cmp++; if (queue_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", queue_count); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        n_cmp++; if ({ctrl_draw, ctrl_clear} !== 2'b00) begin n_err++; $display("FAIL reset_strobes: got %b want 00", {ctrl_draw, ctrl_clear}); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_cmp++; if (issued_count !== 16'd0) begin n_err++; $display("FAIL reset_issued: got %0d want 0", issued_count); end
        n_cmp++; if (dut_fields() !== cmd_t'(0)) begin n_err++; $display("FAIL reset_fields: got %h want 0", dut_fields()); end
        reset = 1'b1;
        step();
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b want 1", idle); end
    endtask

    task automatic test_single_draw();
        cmd_t c;
        int p, draw_hi, bad, scyc;
        bit done;
        busy_len = 10; obs_q.delete(); obs_cyc.delete();
        c = rand_cmd(); c.op = 1'b0; c.addr = 32'h1000;
        push(c);
        p = cyc; draw_hi = 0; bad = 0; done = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (ctrl_draw) draw_hi++;
            if (obs_q.size() != 0 && ctrl_address !== 32'h1000) bad++;
            if (issued_count == 16'd1) begin done = 1; break; end
        end
        scyc = (obs_cyc.size() > 0) ? obs_cyc[0] : -1;
        n_cmp++; if (!done) begin n_err++; $display("FAIL draw_timeout: issued %0d want 1", issued_count); end
        n_cmp++; if (scyc != p + 2) begin n_err++; $display("FAIL draw_latency: strobe cycle %0d want %0d", scyc, p + 2); end
        n_cmp++; if (draw_hi != 1) begin n_err++; $display("FAIL draw_pulse: high cycles %0d want 1", draw_hi); end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL draw_addr_hold: bad cycles %0d want 0", bad); end
        n_cmp++; if (cyc != scyc + 11) begin n_err++; $display("FAIL draw_complete: cycle %0d want %0d", cyc, scyc + 11); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL draw_idle: got %b want 1", idle); end
    endtask

    task automatic test_overflow();
        cmd_t pushed[5];
        cmd_t c;
        busy_len = 8; obs_q.delete(); obs_cyc.delete();
        for (int i = 0; i < 5; i++) begin
            c = rand_cmd(); c.addr = 32'hA000 + 32'(i);
            pushed[i] = c;
            push(c);
            if (i == 3) begin
                n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL ovf_ready: got %b want 0", cmd_ready); end
                n_cmp++; if (queue_count !== 3'd4) begin n_err++; $display("FAIL ovf_count: got %0d want 4", queue_count); end
            end
        end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", overflow); end
        overflow_clear = 1'b1;
        push(rand_cmd());
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
        step();
        overflow_clear = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        for (int i = 0; i < 200; i++) begin
            if (idle) break;
            step();
        end
        n_cmp++; if (obs_q.size() != 4) begin n_err++; $display("FAIL ovf_strobes: got %0d want 4", obs_q.size()); end
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].addr !== pushed[i].addr || obs_q[i].op !== pushed[i].op) begin
                n_err++; $display("FAIL ovf_order[%0d]: got %h/%b want %h/%b", i, obs_q[i].addr, obs_q[i].op, pushed[i].addr, pushed[i].op);
            end
        end
    endtask

    task automatic test_clear_after_draw();
        cmd_t d, c;
        logic [15:0] col_q[$];
        bit clr_q[$], drw_q[$];
        int nclr, ndrw, t, bad;
        busy_len = 3;
        d = rand_cmd(); d.op = 1'b0; d.color = 16'h1234;
        c = rand_cmd(); c.op = 1'b1; c.color = 16'hF801;
        push(d); col_q.push_back(ctrl_clear_color); clr_q.push_back(ctrl_clear); drw_q.push_back(ctrl_draw);
        push(c); col_q.push_back(ctrl_clear_color); clr_q.push_back(ctrl_clear); drw_q.push_back(ctrl_draw);
        for (int i = 0; i < 100; i++) begin
            if (idle) break;
            step();
            col_q.push_back(ctrl_clear_color); clr_q.push_back(ctrl_clear); drw_q.push_back(ctrl_draw);
        end
        nclr = 0; ndrw = 0; t = -1; bad = 0;
        foreach (clr_q[i]) begin
            if (clr_q[i]) begin nclr++; t = i; end
            if (drw_q[i]) ndrw++;
        end
        if (t >= 1) begin
            for (int i = t - 1; i < col_q.size(); i++) if (col_q[i] !== 16'hF801) bad++;
        end else begin
            bad = -1;
        end
        n_cmp++; if (nclr != 1) begin n_err++; $display("FAIL clr_pulse: got %0d want 1", nclr); end
        n_cmp++; if (ndrw != 1) begin n_err++; $display("FAIL clr_draw_pulses: got %0d want 1", ndrw); end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL clr_color_hold: bad %0d want 0", bad); end
        n_cmp++; if (ctrl_draw !== 1'b0) begin n_err++; $display("FAIL clr_draw_low: got %b want 0", ctrl_draw); end
    endtask

    task automatic test_push_pop_same();
        cmd_t a, b, c;
        busy_len = 100; obs_q.delete(); obs_cyc.delete();
        a = rand_cmd(); b = rand_cmd(); c = rand_cmd();
        push(a); push(b);
        for (int i = 0; i < 10; i++) begin
            if (obs_q.size() != 0) break;
            step();
        end
        step(); step();
        n_cmp++; if (queue_count !== 3'd2) begin n_err++; $display("FAIL pp_count_before: got %0d want 2", queue_count); end
        busy_cnt = 0; gpu_busy = 1'b0;
        push(c);
        n_cmp++; if (queue_count !== 3'd2) begin n_err++; $display("FAIL pp_count_after: got %0d want 2", queue_count); end
        busy_len = 2;
        for (int i = 0; i < 100; i++) begin
            if (idle) break;
            step();
        end
        n_cmp++;
        if (obs_q.size() != 3 || obs_q[0].addr !== a.addr || obs_q[1].addr !== b.addr || obs_q[2].addr !== c.addr) begin
            n_err++; $display("FAIL pp_order: got %0d strobes, want %h %h %h", obs_q.size(), a.addr, b.addr, c.addr);
        end
    endtask

    task automatic test_reset_in_wait();
        int p, scyc;
        busy_len = 10; obs_q.delete(); obs_cyc.delete();
        push(rand_cmd());
        for (int i = 0; i < 10; i++) begin
            if (obs_q.size() != 0) break;
            step();
        end
        push(rand_cmd());
        reset = 1'b0; busy_cnt = 0; gpu_busy = 1'b0;
        step();
        n_cmp++; if (queue_count !== 3'd0) begin n_err++; $display("FAIL rw_count: got %0d want 0", queue_count); end
        n_cmp++; if ({ctrl_draw, ctrl_clear} !== 2'b00) begin n_err++; $display("FAIL rw_strobes: got %b want 00", {ctrl_draw, ctrl_clear}); end
        n_cmp++; if (issued_count !== 16'd0) begin n_err++; $display("FAIL rw_issued: got %0d want 0", issued_count); end
        reset = 1'b1; obs_q.delete(); obs_cyc.delete();
        repeat (10) step();
        n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL rw_no_strobe: got %0d want 0", obs_q.size()); end
        busy_len = 0;
        push(rand_cmd());
        p = cyc;
        for (int i = 0; i < 10; i++) begin
            if (obs_q.size() != 0) break;
            step();
        end
        scyc = (obs_cyc.size() > 0) ? obs_cyc[0] : -1;
        n_cmp++; if (scyc != p + 2) begin n_err++; $display("FAIL rw_new_latency: got %0d want %0d", scyc, p + 2); end
        repeat (4) step();
    endtask

    task automatic test_busy_at_push();
        int r, scyc;
        obs_q.delete(); obs_cyc.delete();
        busy_len = 0; force_busy = 1'b1; gpu_busy = 1'b1;
        push(rand_cmd());
        repeat (6) step();
        n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL busy_no_strobe: got %0d want 0", obs_q.size()); end
        n_cmp++; if (queue_count !== 3'd1) begin n_err++; $display("FAIL busy_count: got %0d want 1", queue_count); end
        n_cmp++; if (idle !== 1'b0) begin n_err++; $display("FAIL busy_idle: got %b want 0", idle); end
        force_busy = 1'b0; gpu_busy = 1'b0;
        r = cyc;
        for (int i = 0; i < 10; i++) begin
            if (obs_q.size() != 0) break;
            step();
        end
        scyc = (obs_cyc.size() > 0) ? obs_cyc[0] : -1;
        n_cmp++; if (scyc != r + 2) begin n_err++; $display("FAIL busy_latency: got %0d want %0d", scyc, r + 2); end
        repeat (4) step();
    endtask

    task automatic test_random();
        cmd_t e;
        for (int i = 0; i < 800; i++) begin
            cur            = rand_cmd();
            cmd_valid      = 1'($urandom_range(0, 1));
            overflow_clear = ($urandom_range(0, 9) == 0);
            busy_len       = $urandom_range(0, 4);
            reset          = ($urandom_range(0, 149) != 0);
            if (!reset) begin busy_cnt = 0; gpu_busy = 1'b0; end
            step();
            e = m_ctrl; e.op = 1'b0;
            n_cmp++; if (queue_count !== CW'(mq.size())) begin n_err++; $display("FAIL rnd_count @%0d: got %0d want %0d", cyc, queue_count, mq.size()); end
            n_cmp++; if (cmd_ready !== (mq.size() < DEPTH)) begin n_err++; $display("FAIL rnd_ready @%0d: got %b", cyc, cmd_ready); end
            n_cmp++; if (overflow !== m_ovf) begin n_err++; $display("FAIL rnd_overflow @%0d: got %b want %b", cyc, overflow, m_ovf); end
            n_cmp++; if (issued_count !== m_issued) begin n_err++; $display("FAIL rnd_issued @%0d: got %0d want %0d", cyc, issued_count, m_issued); end
            n_cmp++; if (ctrl_draw !== (m_active && m_age == 1 && !m_ctrl.op)) begin n_err++; $display("FAIL rnd_draw @%0d: got %b", cyc, ctrl_draw); end
            n_cmp++; if (ctrl_clear !== (m_active && m_age == 1 && m_ctrl.op)) begin n_err++; $display("FAIL rnd_clear @%0d: got %b", cyc, ctrl_clear); end
            n_cmp++; if (idle !== (mq.size() == 0 && !m_active && !gpu_busy)) begin n_err++; $display("FAIL rnd_idle @%0d: got %b", cyc, idle); end
            n_cmp++; if (dut_fields() !== e) begin n_err++; $display("FAIL rnd_fields @%0d: got %h want %h", cyc, dut_fields(), e); end
        end
        reset = 1'b1; cmd_valid = 1'b0; overflow_clear = 1'b0;
    endtask

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; overflow_clear = 1'b0; gpu_busy = 1'b0;
        cur = '0; busy_cnt = 0; busy_len = 0; force_busy = 1'b0;
        m_active = 0; m_age = 0; m_ovf = 0; m_issued = '0; m_ctrl = '0;
        test_reset();
        test_single_draw();
        test_overflow();
        test_clear_after_draw();
        test_push_pop_same();
        test_reset_in_wait();
        test_busy_at_push();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpu_cmd_queue.md
GPU_CMD_QUEUE -- requirements
Module: gpu_cmd_queue

Interface
REQ-001 SHALL have parameters: FB_WIDTH, default 400, framebuffer width in pixels.
REQ-002 SHALL have parameters: FB_HEIGHT, default 240, framebuffer height in pixels.
REQ-003 SHALL have parameters: DEPTH, default 4, queue entries (power of two, >=2).
REQ-004 SHALL have ports, in this order:
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-low (0 = reset).
- cmd_valid  in  1  host offers a command this cycle.
- cmd_ready  out  1  queue can accept; equals !full.
- cmd_op  in  1  0 = draw, 1 = clear.
- cmd_address  in  32  image base address.
- cmd_address_x  in  16  image x offset.
- cmd_address_y  in  16  image y offset.
- cmd_image_width  in  16  image width.
- cmd_width  in  clog2(FB_WIDTH)+2  excerpt width.
- cmd_height  in  clog2(FB_HEIGHT)+2  excerpt height.
- cmd_x  in  clog2(FB_WIDTH)+2  screen left.
- cmd_y  in  clog2(FB_HEIGHT)+2  screen top.
- cmd_clear_color  in  16  clear color.
- ctrl_*  out  same widths as cmd_* (address, address_x, address_y, image_width, width, height, x, y, clear_color)  fields to GPU.
- ctrl_draw  out  1  draw strobe to GPU.
- ctrl_clear  out  1  clear strobe to GPU.
- gpu_busy  in  1  GPU busy flag.
- queue_count  out  clog2(DEPTH)+1  occupied entries.
- overflow  out  1  sticky: push attempted while full.
- overflow_clear  in  1  clears overflow.
- issued_count  out  16  commands completed, wraps at 65535->0.
- idle  out  1  queue empty, FSM IDLE, gpu_busy low.

Function
REQ-005 SHALL store commands in a DEPTH-entry FIFO; push on cmd_valid && cmd_ready; all cmd_* fields and cmd_op captured together.
REQ-006 SHALL ignore a push while full, and set overflow the same edge; overflow_clear and a simultaneous set resolve to set.
REQ-007 SHALL, on simultaneous push and pop, keep queue_count unchanged; push while full is not enabled by a same-cycle pop.
REQ-008 SHALL drive ctrl_* fields from the FIFO head combinationally-stable registers; fields change only on a pop.
REQ-009 SHALL run the issue FSM with states IDLE, SETUP, STROBE, WAIT.
REQ-010 SHALL transition IDLE->SETUP when queue non-empty and gpu_busy low.
REQ-011 SHALL hold SETUP exactly one cycle; no strobe asserted; fields from head stable.
REQ-012 SHALL assert exactly one strobe in STROBE for exactly one cycle: ctrl_draw if head op=0, else ctrl_clear; then go to WAIT.
REQ-013 SHALL, in WAIT, hold head fields; when gpu_busy low, pop head, increment issued_count, go IDLE the next edge.
REQ-014 SHALL guarantee both strobes low in every non-STROBE cycle, so each command yields one 0->1 edge.
REQ-015 SHALL have head-to-strobe latency 2 cycles from IDLE with non-empty queue and gpu_busy low.
REQ-016 SHALL have a minimum back-to-back issue period of 4 cycles (SETUP, STROBE, WAIT, IDLE).
REQ-017 SHALL assert idle = (queue_count==0) && FSM==IDLE && !gpu_busy.
REQ-018 SHALL pass field values unmodified; no clipping or arithmetic on them.
REQ-019 SHALL wrap FIFO pointers modulo DEPTH.

Reset
REQ-020 SHALL, while reset=0 at a posedge, empty the FIFO (queue_count=0), set FSM IDLE, and set ctrl_draw=0, ctrl_clear=0, overflow=0, issued_count=0, ctrl_* fields=0.
REQ-021 SHALL, on reset mid-command (SETUP/STROBE/WAIT), abandon the command without pop or issued_count increment; strobes low from the next cycle.

Verification
REQ-022 Single draw, gpu_busy model high 10 cycles after strobe, address=0x1000 -> ctrl_draw high exactly one cycle, 2 cycles after push; ctrl_address=0x1000 held until busy falls; issued_count=1; idle=1.
REQ-023 Push 4 commands (DEPTH=4) back-to-back, then a 5th -> cmd_ready=0 after 4th; 5th dropped; overflow=1; exactly 4 strobes in push order.
REQ-024 Clear with cmd_clear_color=0xF801 after a draw -> ctrl_clear single pulse; ctrl_clear_color=0xF801 stable from SETUP through WAIT exit; ctrl_draw stays 0.
REQ-025 Push and pop same cycle at queue_count=2 -> queue_count remains 2; FIFO order preserved across pointer wrap.
REQ-026 Reset=0 asserted during WAIT -> queue_count=0, strobes 0, issued_count=0; after reset=1, no strobe until a new push.
REQ-027 gpu_busy held high at push -> FSM stays IDLE, no strobe until gpu_busy low, then strobe 2 cycles later.
